// File: rtl/gpr_param.sv
// gpr_param: 2R/1W register file with a multi-cycle clear sweep (clear_req/clear_busy/clear_done).
// Latency: reads combinational, writes visible next cycle, sweep = DEPTH-FIRST busy cycles + 1 done.
// Backpressure: writes during a sweep are dropped (write_dropped); GPR_BYPASS_EN adds write-to-read forwarding.
module gpr_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [ADDR_WIDTH-1:0] rt,
  output logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] b,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] num_write,
  input  logic [DATA_WIDTH-1:0] data_write,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic                  write_dropped
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] FIRST = (ZERO_REG != 0) ? ADDR_WIDTH'(1) : '0;
  localparam logic [ADDR_WIDTH-1:0] LAST  = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    in_clear;
  logic                    write_ok;

  assign in_clear      = (state == ST_CLEAR);
  assign write_ok      = reg_write && !in_clear && !((ZERO_REG != 0) && (num_write == '0));
  assign write_dropped = reg_write & clear_busy;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          clear_done <= 1'b0;
          if (clear_req) begin
            state      <= ST_CLEAR;
            ptr        <= FIRST;
            clear_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (ptr == LAST) begin
            state      <= ST_DONE;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          clear_done <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          clear_busy <= 1'b0;
          clear_done <= 1'b0;
        end
      endcase
    end
  end

  // The sweep owns the write port while in CLEAR; user writes are discarded then.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (in_clear) begin
      mem[ptr] <= '0;
    end else if (write_ok) begin
      mem[num_write] <= data_write;
    end
  end

  always_comb begin
    a = mem[rs];
    b = mem[rt];
`ifdef GPR_BYPASS_EN
    if (write_ok && (rs == num_write)) a = data_write;
    if (write_ok && (rt == num_write)) b = data_write;
`endif
    if ((ZERO_REG != 0) && (rs == '0)) a = '0;
    if ((ZERO_REG != 0) && (rt == '0)) b = '0;
  end

endmodule

// File: doc/gpr_param.md
Name: gpr_param

Overview:
- Parametrised next-generation general-purpose register file for the single-cycle and upcoming multi-cycle CPU datapaths.
- Two asynchronous read ports and one synchronous write port.
- Configurable data width and depth, plus an optional hardwired-zero entry.
- Adds a software-triggered multi-cycle clear sweep with a req/busy/done handshake, and optional write-to-read bypass.

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH entries.
- ZERO_REG, 1: when 1, entry 0 always reads 0 and writes to it are discarded; when 0, entry 0 is ordinary storage.

Ports:
- clock  input  1  single clock, all state updates on posedge.
- reset  input  1  synchronous, active-high.
- rs  input  ADDR_WIDTH  read address, port A.
- rt  input  ADDR_WIDTH  read address, port B.
- a  output  DATA_WIDTH  read data, port A (combinational).
- b  output  DATA_WIDTH  read data, port B (combinational).
- reg_write  input  1  write enable.
- num_write  input  ADDR_WIDTH  write address.
- data_write  input  DATA_WIDTH  write data.
- clear_req  input  1  request a clear sweep; level-sampled in IDLE.
- clear_busy  output  1  sweep in progress.
- clear_done  output  1  one-cycle pulse when the sweep completes.
- write_dropped  output  1  combinational; equals reg_write & clear_busy.

Behaviour:
- Interface:
  - One clock, named clock.
  - Reset is synchronous and active-high, named reset.
- Reset (posedge with reset=1):
  - All DEPTH entries go to 0.
  - FSM goes to IDLE and the sweep pointer to 0.
  - clear_busy=0, clear_done=0.
  - Reset overrides any in-flight sweep and any simultaneous write.
- Reads:
  - a = mem[rs], b = mem[rt], zero latency.
  - With ZERO_REG=1, address 0 returns 0 regardless of storage.
- Writes:
  - In IDLE or DONE, when reg_write=1, mem[num_write] <= data_write at posedge.
  - The write is discarded if ZERO_REG=1 and num_write=0.
  - New data is visible on a/b the cycle after the edge (unless bypass is enabled).
- FSM states: IDLE, CLEAR, DONE.
  - IDLE: clear_req=1 at posedge -> CLEAR. The sweep pointer loads FIRST, where FIRST = 1 if ZERO_REG else 0. A write in the same cycle is still performed.
  - CLEAR, each posedge: mem[ptr] <= 0, ptr <= ptr+1. On the edge that clears ptr = DEPTH-1 -> DONE.
  - DONE: one cycle, then -> IDLE unconditionally. clear_req held high triggers a new sweep only from IDLE.
- Outputs by state:
  - clear_busy = 1 exactly while in CLEAR.
  - clear_done = 1 exactly while in DONE.
  - Both are registered state decodes with no combinational path from inputs.
- Sweep latency:
  - DEPTH-FIRST cycles in CLEAR, then 1 cycle in DONE.
  - Defaults: 31 busy cycles, done pulse on cycle 32 after the request edge.
- During CLEAR:
  - reg_write is ignored and write_dropped=1.
  - Reads return current storage: swept entries read 0, unswept entries keep their old values.
- Pointer width is ADDR_WIDTH; it never wraps because the FSM leaves CLEAR at DEPTH-1.
- rs=rt is legal; both ports return identical data.

Optional Feature:
- Macro GPR_BYPASS_EN.
- Defined:
  - Combinational forwarding applies when reg_write=1 and not in CLEAR, and num_write is not the discarded zero entry.
  - Then a=data_write if rs=num_write, and b=data_write if rt=num_write, in the same cycle.
- Undefined:
  - No forwarding; reads return pre-edge storage until the following cycle.
  - No extra logic is generated.

Test Plan:
- Reset, then read all 32 addresses -> every a/b = 0; clear_busy=0, clear_done=0.
- Write 0xDEADBEEF to r5, then rs=5, rt=0 next cycle -> a=0xDEADBEEF, b=0. Write 0x1234 to r0 -> r0 still reads 0 (ZERO_REG=1).
- Fill r1..r31 with index*0x11, pulse clear_req one cycle:
  - clear_busy high 31 cycles, then clear_done high 1 cycle.
  - Mid-sweep, r20 still reads 0x154 while r3 reads 0.
  - Afterwards all entries read 0.
- Assert reg_write to r7 with 0xAAAA during CLEAR -> write_dropped=1 that cycle; r7=0 after done.
- Assert reset at sweep cycle 10 -> next cycle clear_busy=0, all entries 0, no clear_done pulse.
- GPR_BYPASS_EN defined: reg_write r9=0x55AA with rs=9 in the same cycle -> a=0x55AA before the edge. Undefined -> a = old r9 value.
